// File: rtl/data_stack_unit.sv
// Operand stack: one PUSH/POP/REPLACE per cycle, top and next-to-top held in registers for the ALU.
// Latency 1: every command is reflected on the outputs the cycle after it is sampled.
// No backpressure: a command is accepted every cycle; illegal ones are dropped and flagged via sticky errors.
module data_stack_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int ULA_WIDTH  = 24,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            CMD,
    input  logic [1:0]            SEL_SRC,
    input  logic [ULA_WIDTH-1:0]  ULA_IN,
    input  logic [DATA_WIDTH-1:0] MEM_EXT_IN,
    input  logic [DATA_WIDTH-1:0] ARG_IN,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] STACK_OUT,
    output logic [DATA_WIDTH-1:0] NEXT_OUT,
    output logic [ADDR_WIDTH-1:0] TOS_OUT,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ERR_OVERFLOW,
    output logic                  ERR_UNDERFLOW
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0] CNT_TWO  = (DEPTH_LOG2 + 1)'(2);
    localparam logic [DEPTH_LOG2:0] CNT_TRI  = (DEPTH_LOG2 + 1)'(3);

    typedef enum logic [1:0] {
        CMD_NOP     = 2'b00,
        CMD_PUSH    = 2'b01,
        CMD_POP     = 2'b10,
        CMD_REPLACE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        SRC_ULA  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_ARG  = 2'b10,
        SRC_DUP  = 2'b11
    } src_e;

    // Full backing store: mem[cnt-1] mirrors top, mem[cnt-2] mirrors next.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_LOG2:0]   cnt_q, cnt_nxt;
    logic [DATA_WIDTH-1:0] top_q, top_nxt;
    logic [DATA_WIDTH-1:0] nxt_q, nxt_nxt;
    logic                  ovf_q, ovf_nxt;
    logic                  unf_q, unf_nxt;

    cmd_e                  cmd;
    src_e                  src;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic                  is_full, is_empty;
    logic                  do_push, do_pop, do_repl;
    logic                  ovf_evt, unf_evt;
    logic [DEPTH_LOG2:0]   cnt_m1, cnt_m3;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;

    assign cmd = cmd_e'(CMD);
    assign src = src_e'(SEL_SRC);

    generate
        if (ULA_WIDTH > DATA_WIDTH) begin : g_ula_hi
            logic unused_ula_hi;
            assign unused_ula_hi = ^ULA_IN[ULA_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        wr_dat = '0;
        case (src)
            SRC_ULA: wr_dat = ULA_IN[DATA_WIDTH-1:0];
            SRC_MEM: wr_dat = MEM_EXT_IN;
            SRC_ARG: wr_dat = ARG_IN;
            SRC_DUP: wr_dat = top_q;
            default: wr_dat = '0;
        endcase
    end

    assign is_full  = (cnt_q == CNT_FULL);
    assign is_empty = (cnt_q == '0);
    assign cnt_m1   = cnt_q - CNT_ONE;
    assign cnt_m3   = cnt_q - CNT_TRI;

    assign do_push  = (cmd == CMD_PUSH) && !is_full;
    assign do_pop   = (cmd == CMD_POP) && !is_empty;
    assign do_repl  = (cmd == CMD_REPLACE) && !is_empty;
    assign ovf_evt  = (cmd == CMD_PUSH) && is_full;
    assign unf_evt  = ((cmd == CMD_POP) || (cmd == CMD_REPLACE)) && is_empty;

    always_comb begin
        cnt_nxt = cnt_q;
        top_nxt = top_q;
        nxt_nxt = nxt_q;
        if (do_push) begin
            cnt_nxt = cnt_q + CNT_ONE;
            top_nxt = wr_dat;
            nxt_nxt = top_q;
        end else if (do_pop) begin
            cnt_nxt = cnt_m1;
            top_nxt = nxt_q;
            // Refill next from the store; the entry below next lives at cnt-3.
            nxt_nxt = (cnt_q >= CNT_TRI) ? mem[cnt_m3[DEPTH_LOG2-1:0]] : '0;
        end else if (do_repl) begin
            top_nxt = wr_dat;
        end
    end

    // A fresh error in the same cycle as CLR_ERR takes priority over the clear.
    assign ovf_nxt = ovf_evt | (ovf_q & ~CLR_ERR);
    assign unf_nxt = unf_evt | (unf_q & ~CLR_ERR);

    assign mem_we    = do_push | do_repl;
    assign mem_waddr = do_push ? cnt_q[DEPTH_LOG2-1:0] : cnt_m1[DEPTH_LOG2-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            top_q <= '0;
            nxt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            top_q <= top_nxt;
            nxt_q <= nxt_nxt;
            ovf_q <= ovf_nxt;
            unf_q <= unf_nxt;
        end
    end

    // Storage is deliberately left out of reset; count gates every read.
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem[mem_waddr] <= wr_dat;
        end
    end

    assign STACK_OUT     = top_q;
    assign NEXT_OUT      = nxt_q;
    assign TOS_OUT       = ADDR_WIDTH'(cnt_q);
    assign FULL          = is_full;
    assign EMPTY         = is_empty;
    assign ERR_OVERFLOW  = ovf_q;
    assign ERR_UNDERFLOW = unf_q;

    // CNT_TWO documents the threshold below which NEXT_OUT reads as zero.
    logic unused_cnt_two;
    assign unused_cnt_two = ^CNT_TWO;

endmodule

// File: tb/tb_data_stack_unit.sv
// Directed bench for data_stack_unit: each task drives one scenario and checks hand-computed results.
module tb_data_stack_unit;

    localparam logic [1:0] NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, REPL = 2'b11;
    localparam logic [1:0] S_ULA = 2'b00, S_MEM = 2'b01, S_ARG = 2'b10, S_DUP = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cmd = NOP;
    logic [1:0]  sel_src = S_ARG;
    logic [23:0] ula_in = '0;
    logic [7:0]  mem_ext_in = '0;
    logic [7:0]  arg_in = '0;
    logic        clr_err = 1'b0;
    logic [7:0]  stack_out, next_out;
    logic [11:0] tos_out;
    logic        full, empty, err_overflow, err_underflow;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    data_stack_unit dut (
        .clk(clk), .reset(reset), .CMD(cmd), .SEL_SRC(sel_src),
        .ULA_IN(ula_in), .MEM_EXT_IN(mem_ext_in), .ARG_IN(arg_in), .CLR_ERR(clr_err),
        .STACK_OUT(stack_out), .NEXT_OUT(next_out), .TOS_OUT(tos_out),
        .FULL(full), .EMPTY(empty), .ERR_OVERFLOW(err_overflow), .ERR_UNDERFLOW(err_underflow)
    );

    // Drive one command for exactly one rising edge, then return to NOP 1 time unit after the edge.
    task automatic do_cmd(input logic [1:0] c, input logic [1:0] s, input logic [23:0] u,
                          input logic [7:0] m, input logic [7:0] a, input logic clr);
        cmd = c; sel_src = s; ula_in = u; mem_ext_in = m; arg_in = a; clr_err = clr;
        @(posedge clk);
        #1;
        cmd = NOP; clr_err = 1'b0;
    endtask

    task automatic apply_reset();
        cmd = NOP; clr_err = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        vec++;
        if ({stack_out, next_out, tos_out} !== {8'h00, 8'h00, 12'd0}) begin
            errs++; $display("FAIL reset_data: got %h/%h/%0d want 00/00/0", stack_out, next_out, tos_out);
        end
        @(negedge clk); @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if ({empty, full, err_overflow, err_underflow, tos_out} !== {4'b1000, 12'd0}) begin
            errs++; $display("FAIL reset_idle_flags: got e%b f%b o%b u%b tos%0d want e1 f0 o0 u0 tos0",
                             empty, full, err_overflow, err_underflow, tos_out);
        end
    endtask

    task automatic test_push_sources();
        apply_reset();
        do_cmd(PUSH, S_ARG, 24'h000044, 8'h55, 8'h11, 1'b0);
        do_cmd(PUSH, S_MEM, 24'h000077, 8'h22, 8'h66, 1'b0);
        do_cmd(PUSH, S_ULA, 24'hABC033, 8'h99, 8'h88, 1'b0);
        vec++;
        if ({stack_out, next_out, tos_out} !== {8'h33, 8'h22, 12'd3}) begin
            errs++; $display("FAIL push3: got %h/%h/%0d want 33/22/3", stack_out, next_out, tos_out);
        end
        do_cmd(POP, S_ARG, 24'h0, 8'h0, 8'hFF, 1'b0);
        vec++;
        if ({stack_out, next_out, tos_out, empty} !== {8'h22, 8'h11, 12'd2, 1'b0}) begin
            errs++; $display("FAIL pop_after_push3: got %h/%h/%0d e%b want 22/11/2 e0",
                             stack_out, next_out, tos_out, empty);
        end
    endtask

    task automatic test_dup_replace();
        apply_reset();
        do_cmd(PUSH, S_ARG, 24'h0, 8'h0, 8'h05, 1'b0);
        do_cmd(PUSH, S_DUP, 24'h0000AA, 8'hBB, 8'hCC, 1'b0);
        vec++;
        if ({stack_out, next_out, tos_out} !== {8'h05, 8'h05, 12'd2}) begin
            errs++; $display("FAIL dup: got %h/%h/%0d want 05/05/2", stack_out, next_out, tos_out);
        end
        do_cmd(REPL, S_ARG, 24'h0, 8'h0, 8'h07, 1'b0);
        vec++;
        if ({stack_out, next_out, tos_out} !== {8'h07, 8'h05, 12'd2}) begin
            errs++; $display("FAIL replace: got %h/%h/%0d want 07/05/2", stack_out, next_out, tos_out);
        end
        // NOP with every source wiggling must leave state alone.
        do_cmd(NOP, S_ULA, 24'h1234EE, 8'hEE, 8'hEE, 1'b0);
        do_cmd(NOP, S_DUP, 24'h0, 8'h0, 8'h0, 1'b0);
        vec++;
        if ({stack_out, next_out, tos_out} !== {8'h07, 8'h05, 12'd2}) begin
            errs++; $display("FAIL nop_hold: got %h/%h/%0d want 07/05/2", stack_out, next_out, tos_out);
        end
        do_cmd(POP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b0);
        do_cmd(PUSH, S_MEM, 24'h0, 8'h3C, 8'h0, 1'b0);
        do_cmd(PUSH, S_ARG, 24'h0, 8'h0, 8'h4D, 1'b0);
        do_cmd(POP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b0);
        do_cmd(POP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b0);
        vec++;
        if ({stack_out, next_out, tos_out} !== {8'h05, 8'h00, 12'd1}) begin
            errs++; $display("FAIL deep_pop_after_replace: got %h/%h/%0d want 05/00/1",
                             stack_out, next_out, tos_out);
        end
    endtask

    task automatic test_full_overflow();
        logic [7:0] exp_top, exp_nxt;
        int exp_cnt;
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            do_cmd(PUSH, S_ARG, 24'hFFFF00, 8'hFF, 8'(i), 1'b0);
            if (i == 30) begin
                vec++;
                if ({full, tos_out} !== {1'b0, 12'd31}) begin
                    errs++; $display("FAIL almost_full: got f%b tos%0d want f0 tos31", full, tos_out);
                end
            end
        end
        vec++;
        if ({full, empty, tos_out, stack_out, next_out} !== {2'b10, 12'd32, 8'd31, 8'd30}) begin
            errs++; $display("FAIL full: got f%b e%b tos%0d top%0d nxt%0d want f1 e0 tos32 top31 nxt30",
                             full, empty, tos_out, stack_out, next_out);
        end
        do_cmd(PUSH, S_ARG, 24'h0, 8'h0, 8'hEE, 1'b0);
        vec++;
        if ({err_overflow, tos_out, stack_out, next_out} !== {1'b1, 12'd32, 8'd31, 8'd30}) begin
            errs++; $display("FAIL overflow: got o%b tos%0d top%0d nxt%0d want o1 tos32 top31 nxt30",
                             err_overflow, tos_out, stack_out, next_out);
        end
        for (int k = 1; k <= 32; k++) begin
            do_cmd(POP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b0);
            exp_cnt = 32 - k;
            exp_top = (k < 32) ? 8'(31 - k) : 8'h00;
            exp_nxt = (exp_cnt >= 2) ? 8'(30 - k) : 8'h00;
            vec++;
            if ({stack_out, next_out, tos_out} !== {exp_top, exp_nxt, 12'(exp_cnt)}) begin
                errs++; $display("FAIL pop_%0d: got %h/%h/%0d want %h/%h/%0d", k,
                                 stack_out, next_out, tos_out, exp_top, exp_nxt, exp_cnt);
            end
        end
        vec++;
        if ({empty, full, err_underflow, err_overflow} !== 4'b1001) begin
            errs++; $display("FAIL drained: got e%b f%b u%b o%b want e1 f0 u0 o1",
                             empty, full, err_underflow, err_overflow);
        end
    endtask

    task automatic test_underflow_clr();
        apply_reset();
        do_cmd(POP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b0);
        vec++;
        if ({err_underflow, err_overflow, tos_out, stack_out, empty} !== {2'b10, 12'd0, 8'h00, 1'b1}) begin
            errs++; $display("FAIL underflow: got u%b o%b tos%0d top%h e%b want u1 o0 tos0 top00 e1",
                             err_underflow, err_overflow, tos_out, stack_out, empty);
        end
        do_cmd(POP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b1);
        vec++;
        if (err_underflow !== 1'b1) begin
            errs++; $display("FAIL clr_vs_new_err: got %b want 1", err_underflow);
        end
        do_cmd(NOP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b1);
        vec++;
        if (err_underflow !== 1'b0) begin
            errs++; $display("FAIL clr_alone: got %b want 0", err_underflow);
        end
        do_cmd(REPL, S_ARG, 24'h0, 8'h0, 8'h42, 1'b0);
        vec++;
        if ({err_underflow, tos_out, stack_out} !== {1'b1, 12'd0, 8'h00}) begin
            errs++; $display("FAIL replace_empty: got u%b tos%0d top%h want u1 tos0 top00",
                             err_underflow, tos_out, stack_out);
        end
        do_cmd(NOP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b1);
        do_cmd(NOP, S_ARG, 24'h0, 8'h0, 8'h0, 1'b0);
        vec++;
        if (err_underflow !== 1'b0) begin
            errs++; $display("FAIL clr_hold: got %b want 0", err_underflow);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 1; i <= 4; i++) do_cmd(PUSH, S_ARG, 24'h0, 8'h0, 8'(i), 1'b0);
        vec++;
        if ({tos_out, stack_out, next_out} !== {12'd4, 8'h04, 8'h03}) begin
            errs++; $display("FAIL pre_reset: got tos%0d %h/%h want tos4 04/03", tos_out, stack_out, next_out);
        end
        // Raise a PUSH and pull reset between edges: nothing of the PUSH may land.
        @(negedge clk);
        cmd = PUSH; sel_src = S_ARG; arg_in = 8'h77;
        #2 reset = 1'b0;
        #1;
        vec++;
        if ({stack_out, next_out, tos_out, empty, full, err_overflow, err_underflow} !==
            {8'h00, 8'h00, 12'd0, 4'b1000}) begin
            errs++; $display("FAIL async_reset: got %h/%h/%0d e%b f%b o%b u%b want 00/00/0 e1 f0 o0 u0",
                             stack_out, next_out, tos_out, empty, full, err_overflow, err_underflow);
        end
        @(posedge clk); #1;
        cmd = NOP;
        @(negedge clk); reset = 1'b1;
        do_cmd(PUSH, S_ARG, 24'h0, 8'h0, 8'h09, 1'b0);
        vec++;
        if ({tos_out, stack_out, next_out} !== {12'd1, 8'h09, 8'h00}) begin
            errs++; $display("FAIL post_reset_push: got tos%0d %h/%h want tos1 09/00", tos_out, stack_out, next_out);
        end
    endtask

    initial begin
        test_reset();
        test_push_sources();
        test_dup_replace();
        test_full_overflow();
        test_underflow_clr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
